writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of queue entries; the only legal values are 2, 4, 8 and 16.
REQ-002 Parameter B_WORD, default 32, SHALL set the data width of every data port.
REQ-003 clk_cpu  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk_cpu.
REQ-005 ld_valid / ld_adrs / ld_data  in  1 / 5 / B_WORD  SHALL carry the load-unit writeback request.
REQ-006 ld_ready  out  1  SHALL mean a load request is accepted this cycle if ld_valid is high.
REQ-007 alu_valid / alu_adrs / alu_data  in  1 / 5 / B_WORD  SHALL carry the ALU writeback request.
REQ-008 alu_ready  out  1  SHALL mean an ALU request is accepted this cycle if alu_valid is high.
REQ-009 wr_en / wr_adrs / wr_data  out  1 / 5 / B_WORD  SHALL drive the register-file write port.
REQ-010 rd_adrs_a, rd_adrs_b  in  5 each  SHALL be the register-file read addresses, used for bypass lookup.
REQ-011 fwd_hit_a, fwd_hit_b  out  1 each  SHALL flag a pending queued write to the matching read address.
REQ-012 fwd_data_a, fwd_data_b  out  B_WORD each  SHALL carry the bypass data.
REQ-013 count  out  log2(DEPTH)+1  SHALL give the number of occupied entries.
REQ-014 empty, full  out  1 each  SHALL mean count==0 and count==DEPTH respectively.

Function
REQ-015 Storage SHALL be a circular FIFO of DEPTH entries {adrs[4:0], data}, with read and write pointers wrapping modulo DEPTH.
REQ-016 A handshake SHALL complete on a cycle with valid & ready high at the clock edge; the data SHALL be sampled on that edge.
REQ-017 Both ready outputs SHALL be computed combinationally from registered count and ld_valid only, never from the same cycle's dequeue.
REQ-018 Free space SHALL be free = DEPTH - count.
REQ-019 ld_ready SHALL be 1 when free >= 1.
REQ-020 alu_ready SHALL be 1 when free >= 2, or when free == 1 and ld_valid == 0.
REQ-021 When both requests are accepted in one cycle, the load entry SHALL be enqueued first (older) and the ALU entry second.
REQ-022 An accepted request with address 0 SHALL complete the handshake but SHALL NOT be stored, consuming no entry.
REQ-023 When count > 0 and reset is low, wr_en SHALL be 1 and wr_adrs/wr_data SHALL equal the head entry, all combinational.
REQ-024 The head entry SHALL be dequeued on every edge where wr_en is 1.
REQ-025 When count == 0, wr_en SHALL be 0 and wr_adrs/wr_data SHALL be 0.
REQ-026 Latency: an entry accepted at edge N into an empty queue SHALL appear on the write port during cycle N..N+1 and be written by the register file at edge N+1.
REQ-027 An entry SHALL never be written at the edge on which it is accepted.
REQ-028 Next count SHALL equal count + enqueued entries (0, 1 or 2) - dequeued entries (0 or 1); count SHALL never exceed DEPTH or underflow.
REQ-029 Bypass port x: fwd_hit_x SHALL be 1 if any stored entry has adrs == rd_adrs_x and rd_adrs_x != 0.
REQ-030 fwd_data_x SHALL be the data of the youngest such entry, or 0 when there is no hit.
REQ-031 Bypass lookup SHALL include the head entry currently on the write port and SHALL exclude requests being accepted this cycle.
REQ-032 Multiple queued writes to the same address SHALL all be issued, in order; no coalescing.

Reset
REQ-033 While reset is high at an edge, pointers and count SHALL clear to 0 and all stored entries SHALL be discarded.
REQ-034 While reset is high, wr_en, ld_ready, alu_ready, fwd_hit_a and fwd_hit_b SHALL be forced to 0 combinationally.
REQ-035 After reset, outputs SHALL be count=0, empty=1, full=0 and all data outputs 0.
REQ-036 Reset asserted mid-operation SHALL drop queued entries without issuing them, and SHALL take priority over simultaneous handshakes.

Verification
REQ-037 Empty queue; ld (adrs 5, 0x11) and alu (adrs 6, 0x22) valid in the same cycle -> both accepted; next cycle wr 5/0x11; following cycle wr 6/0x22; then empty=1.
REQ-038 DEPTH=4 with count=3; ld and alu both valid -> ld_ready=1, alu_ready=0; next cycle count=3 (one enqueued, one dequeued), full=0.
REQ-039 Queue holds adrs 7 = 0xA then adrs 7 = 0xB; rd_adrs_a=7 -> fwd_hit_a=1, fwd_data_a=0xB; rd_adrs_b=0 -> fwd_hit_b=0.
REQ-040 alu_valid with adrs 0, data 0xFF -> alu_ready=1, count unchanged, wr_en never asserted for it.
REQ-041 Fill to full (count=4), then assert reset for one cycle while ld_valid=1 -> no wr_en during reset; afterwards count=0, empty=1, and the load is not enqueued.
REQ-042 Random two-producer traffic over 10k cycles against a reference queue model -> write-port sequence matches in order, count never exceeds DEPTH, bypass always returns the youngest matching entry.

Source files
------------

// File: rtl/writeback_queue.sv
// Writeback queue: merges load-unit and ALU register writebacks into one
// register-file write port, with read-address bypass from queued entries.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int B_WORD = 32
) (
    input  logic                    clk_cpu,
    input  logic                    reset,
    input  logic                    ld_valid,
    input  logic [4:0]              ld_adrs,
    input  logic [B_WORD-1:0]       ld_data,
    output logic                    ld_ready,
    input  logic                    alu_valid,
    input  logic [4:0]              alu_adrs,
    input  logic [B_WORD-1:0]       alu_data,
    output logic                    alu_ready,
    output logic                    wr_en,
    output logic [4:0]              wr_adrs,
    output logic [B_WORD-1:0]       wr_data,
    input  logic [4:0]              rd_adrs_a,
    input  logic [4:0]              rd_adrs_b,
    output logic                    fwd_hit_a,
    output logic                    fwd_hit_b,
    output logic [B_WORD-1:0]       fwd_data_a,
    output logic [B_WORD-1:0]       fwd_data_b,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]        mem_adrs [DEPTH];
    logic [B_WORD-1:0] mem_data [DEPTH];
    logic [PW-1:0]     rptr, wptr, alu_slot, idx;
    logic [CW-1:0]     free;
    logic              ld_store, alu_store, deq;

    // Readiness looks only at registered occupancy, never at this cycle's dequeue.
    always_comb begin
        free      = CW'(DEPTH) - count;
        ld_ready  = !reset && (free >= CW'(1));
        alu_ready = !reset && ((free >= CW'(2)) || ((free == CW'(1)) && !ld_valid));
        ld_store  = ld_valid && ld_ready && (ld_adrs != 5'd0);
        alu_store = alu_valid && alu_ready && (alu_adrs != 5'd0);
        alu_slot  = ld_store ? wptr + PW'(1) : wptr;
        deq       = !reset && (count != '0);
        wr_en     = deq;
        wr_adrs   = deq ? mem_adrs[rptr] : '0;
        wr_data   = deq ? mem_data[rptr] : '0;
        empty     = (count == '0);
        full      = (count == CW'(DEPTH));
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (ld_store) begin
                mem_adrs[wptr] <= ld_adrs;
                mem_data[wptr] <= ld_data;
            end
            if (alu_store) begin
                mem_adrs[alu_slot] <= alu_adrs;
                mem_data[alu_slot] <= alu_data;
            end
            wptr  <= wptr + PW'(ld_store) + PW'(alu_store);
            rptr  <= rptr + PW'(deq);
            count <= count + CW'(ld_store) + CW'(alu_store) - CW'(deq);
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        fwd_hit_a  = 1'b0;
        fwd_hit_b  = 1'b0;
        fwd_data_a = '0;
        fwd_data_b = '0;
        idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rptr + PW'(i);
            if (CW'(i) < count) begin
                if ((rd_adrs_a != 5'd0) && (mem_adrs[idx] == rd_adrs_a)) begin
                    fwd_hit_a  = 1'b1;
                    fwd_data_a = mem_data[idx];
                end
                if ((rd_adrs_b != 5'd0) && (mem_adrs[idx] == rd_adrs_b)) begin
                    fwd_hit_b  = 1'b1;
                    fwd_data_b = mem_data[idx];
                end
            end
        end
        if (reset) begin
            fwd_hit_a  = 1'b0;
            fwd_hit_b  = 1'b0;
            fwd_data_a = '0;
            fwd_data_b = '0;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed vector table, a DEPTH=2 full/reset
// sequence, and random two-producer traffic against a queue model.
module tb_writeback_queue;

    localparam int DEPTH  = 4;
    localparam int B_WORD = 32;

    logic clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    logic                   reset, ld_valid, alu_valid, ld_ready, alu_ready, wr_en;
    logic [4:0]             ld_adrs, alu_adrs, wr_adrs, rd_adrs_a, rd_adrs_b;
    logic [B_WORD-1:0]      ld_data, alu_data, wr_data, fwd_data_a, fwd_data_b;
    logic                   fwd_hit_a, fwd_hit_b, empty, full;
    logic [$clog2(DEPTH):0] count;

    logic                   d2_reset, d2_ld_valid, d2_alu_valid, d2_ld_ready, d2_alu_ready, d2_wr_en;
    logic [4:0]             d2_ld_adrs, d2_alu_adrs, d2_wr_adrs, d2_rd_adrs_a, d2_rd_adrs_b;
    logic [B_WORD-1:0]      d2_ld_data, d2_alu_data, d2_wr_data, d2_fwd_data_a, d2_fwd_data_b;
    logic                   d2_fwd_hit_a, d2_fwd_hit_b, d2_empty, d2_full;
    logic [1:0]             d2_count;

    writeback_queue #(.DEPTH(DEPTH), .B_WORD(B_WORD)) dut (
        .clk_cpu(clk_cpu), .reset(reset),
        .ld_valid(ld_valid), .ld_adrs(ld_adrs), .ld_data(ld_data), .ld_ready(ld_ready),
        .alu_valid(alu_valid), .alu_adrs(alu_adrs), .alu_data(alu_data), .alu_ready(alu_ready),
        .wr_en(wr_en), .wr_adrs(wr_adrs), .wr_data(wr_data),
        .rd_adrs_a(rd_adrs_a), .rd_adrs_b(rd_adrs_b),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
        .count(count), .empty(empty), .full(full)
    );

    writeback_queue #(.DEPTH(2), .B_WORD(B_WORD)) d2 (
        .clk_cpu(clk_cpu), .reset(d2_reset),
        .ld_valid(d2_ld_valid), .ld_adrs(d2_ld_adrs), .ld_data(d2_ld_data), .ld_ready(d2_ld_ready),
        .alu_valid(d2_alu_valid), .alu_adrs(d2_alu_adrs), .alu_data(d2_alu_data), .alu_ready(d2_alu_ready),
        .wr_en(d2_wr_en), .wr_adrs(d2_wr_adrs), .wr_data(d2_wr_data),
        .rd_adrs_a(d2_rd_adrs_a), .rd_adrs_b(d2_rd_adrs_b),
        .fwd_hit_a(d2_fwd_hit_a), .fwd_hit_b(d2_fwd_hit_b),
        .fwd_data_a(d2_fwd_data_a), .fwd_data_b(d2_fwd_data_b),
        .count(d2_count), .empty(d2_empty), .full(d2_full)
    );

    typedef struct packed {
        logic [4:0]        a;
        logic [B_WORD-1:0] d;
    } ent_t;
    ent_t q[$];

    typedef struct {
        int rst, lv, la, ldd, av, aa, ad, ra, rb;
        int e_lr, e_ar, e_we, e_wa, e_wd, e_cnt, e_ha, e_da, e_hb;
    } vec_t;
    vec_t vecs[$];

    int errors = 0;
    int checks = 0;
    logic m_ld_acc, m_alu_acc, m_deq, m_rst;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    function automatic void exp_fwd(input logic [4:0] rd, output logic hit, output logic [B_WORD-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (!reset && rd != 5'd0)
            foreach (q[k])
                if (q[k].a == rd) begin
                    hit  = 1'b1;
                    data = q[k].d;
                end
    endfunction

    // Compare every main-DUT output against the queue model for this cycle.
    task automatic model_check();
        int n;
        int fr;
        logic e_lr, e_ar, e_we, h;
        logic [B_WORD-1:0] d;
        n    = q.size();
        fr   = DEPTH - n;
        e_lr = !reset && (fr >= 1);
        e_ar = !reset && ((fr >= 2) || (fr == 1 && !ld_valid));
        e_we = !reset && (n > 0);
        chk("ld_ready", 64'(ld_ready), 64'(e_lr));
        chk("alu_ready", 64'(alu_ready), 64'(e_ar));
        chk("wr_en", 64'(wr_en), 64'(e_we));
        if (wr_en === 1'b1 && n > 0) begin
            chk("wr_adrs", 64'(wr_adrs), 64'(q[0].a));
            chk("wr_data", 64'(wr_data), 64'(q[0].d));
        end
        chk("count", 64'(count), 64'(n));
        chk("empty", 64'(empty), 64'(n == 0));
        chk("full", 64'(full), 64'(n == DEPTH));
        exp_fwd(rd_adrs_a, h, d);
        chk("fwd_hit_a", 64'(fwd_hit_a), 64'(h));
        chk("fwd_data_a", 64'(fwd_data_a), 64'(d));
        exp_fwd(rd_adrs_b, h, d);
        chk("fwd_hit_b", 64'(fwd_hit_b), 64'(h));
        chk("fwd_data_b", 64'(fwd_data_b), 64'(d));
        m_ld_acc  = ld_valid && e_lr;
        m_alu_acc = alu_valid && e_ar;
        m_deq     = e_we;
        m_rst     = reset;
    endtask

    task automatic advance();
        @(posedge clk_cpu);
        if (m_rst) q.delete();
        else begin
            if (m_deq) void'(q.pop_front());
            if (m_ld_acc && ld_adrs != 5'd0) q.push_back('{a: ld_adrs, d: ld_data});
            if (m_alu_acc && alu_adrs != 5'd0) q.push_back('{a: alu_adrs, d: alu_data});
        end
        @(negedge clk_cpu);
    endtask

    task automatic drive(input vec_t v);
        reset     = v.rst[0];
        ld_valid  = v.lv[0];
        ld_adrs   = 5'(v.la);
        ld_data   = B_WORD'(v.ldd);
        alu_valid = v.av[0];
        alu_adrs  = 5'(v.aa);
        alu_data  = B_WORD'(v.ad);
        rd_adrs_a = 5'(v.ra);
        rd_adrs_b = 5'(v.rb);
    endtask

    initial begin
        vec_t v;
        int pct;
        logic [63:0] e_cnt64;

        reset = 1'b1; ld_valid = 1'b0; ld_adrs = '0; ld_data = '0;
        alu_valid = 1'b0; alu_adrs = '0; alu_data = '0; rd_adrs_a = '0; rd_adrs_b = '0;
        d2_reset = 1'b1; d2_ld_valid = 1'b0; d2_ld_adrs = '0; d2_ld_data = '0;
        d2_alu_valid = 1'b0; d2_alu_adrs = '0; d2_alu_data = '0;
        d2_rd_adrs_a = '0; d2_rd_adrs_b = '0;

        //         rst lv la ldd     av aa ad      ra rb  lr ar we wa wd      cnt ha da      hb
        vecs.push_back('{0, 1, 5, 'h11,  1, 6, 'h22,  5, 6,  1, 1, 0, 0, 0,      0, 0, 0,      0});
        vecs.push_back('{0, 0, 0, 0,     0, 0, 0,     5, 6,  1, 1, 1, 5, 'h11,   2, 1, 'h11,   1});
        vecs.push_back('{0, 0, 0, 0,     0, 0, 0,     5, 6,  1, 1, 1, 6, 'h22,   1, 0, 0,      1});
        vecs.push_back('{0, 0, 0, 0,     0, 0, 0,     5, 6,  1, 1, 0, 0, 0,      0, 0, 0,      0});
        vecs.push_back('{0, 1, 7, 'hA,   1, 7, 'hB,   7, 0,  1, 1, 0, 0, 0,      0, 0, 0,      0});
        vecs.push_back('{0, 0, 0, 0,     1, 0, 'hFF,  7, 0,  1, 1, 1, 7, 'hA,    2, 1, 'hB,    0});
        vecs.push_back('{0, 0, 0, 0,     0, 0, 0,     7, 0,  1, 1, 1, 7, 'hB,    1, 1, 'hB,    0});
        vecs.push_back('{0, 0, 0, 0,     0, 0, 0,     7, 0,  1, 1, 0, 0, 0,      0, 0, 0,      0});
        vecs.push_back('{0, 1, 1, 'h101, 1, 2, 'h102, 0, 0,  1, 1, 0, 0, 0,      0, 0, 0,      0});
        vecs.push_back('{0, 1, 3, 'h103, 1, 4, 'h104, 0, 0,  1, 1, 1, 1, 'h101,  2, 0, 0,      0});
        vecs.push_back('{0, 1, 8, 'h108, 1, 9, 'h109, 9, 8,  1, 0, 1, 2, 'h102,  3, 0, 0,      0});
        vecs.push_back('{0, 0, 0, 0,     0, 0, 0,     9, 8,  1, 1, 1, 3, 'h103,  3, 0, 0,      1});
        vecs.push_back('{0, 0, 0, 0,     0, 0, 0,     4, 0,  1, 1, 1, 4, 'h104,  2, 1, 'h104,  0});
        vecs.push_back('{0, 0, 0, 0,     0, 0, 0,     0, 0,  1, 1, 1, 8, 'h108,  1, 0, 0,      0});
        vecs.push_back('{0, 0, 0, 0,     0, 0, 0,     0, 0,  1, 1, 0, 0, 0,      0, 0, 0,      0});
        vecs.push_back('{0, 1, 1, 1,     1, 2, 2,     0, 0,  1, 1, 0, 0, 0,      0, 0, 0,      0});
        vecs.push_back('{0, 1, 3, 3,     1, 4, 4,     3, 0,  1, 1, 1, 1, 1,      2, 0, 0,      0});
        vecs.push_back('{1, 1, 5, 5,     0, 0, 0,     3, 0,  0, 0, 0, 0, 0,      3, 0, 0,      0});
        vecs.push_back('{0, 0, 0, 0,     0, 0, 0,     3, 5,  1, 1, 0, 0, 0,      0, 0, 0,      0});
        vecs.push_back('{0, 0, 0, 0,     0, 0, 0,     3, 5,  1, 1, 0, 0, 0,      0, 0, 0,      0});

        repeat (2) @(posedge clk_cpu);
        @(negedge clk_cpu);
        #1;
        chk("rst_ld_ready", 64'(ld_ready), 64'(0));
        chk("rst_alu_ready", 64'(alu_ready), 64'(0));
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        reset = 1'b0;
        d2_reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v);
            #1;
            model_check();
            e_cnt64 = 64'(v.e_cnt);
            chk($sformatf("v%0d_ld_ready", i), 64'(ld_ready), 64'(v.e_lr));
            chk($sformatf("v%0d_alu_ready", i), 64'(alu_ready), 64'(v.e_ar));
            chk($sformatf("v%0d_wr_en", i), 64'(wr_en), 64'(v.e_we));
            if (v.rst == 0) begin
                chk($sformatf("v%0d_wr_adrs", i), 64'(wr_adrs), 64'(v.e_wa));
                chk($sformatf("v%0d_wr_data", i), 64'(wr_data), 64'(v.e_wd));
            end
            chk($sformatf("v%0d_count", i), 64'(count), e_cnt64);
            chk($sformatf("v%0d_empty", i), 64'(empty), 64'(v.e_cnt == 0));
            chk($sformatf("v%0d_full", i), 64'(full), 64'(v.e_cnt == DEPTH));
            chk($sformatf("v%0d_fwd_hit_a", i), 64'(fwd_hit_a), 64'(v.e_ha));
            chk($sformatf("v%0d_fwd_data_a", i), 64'(fwd_data_a), 64'(v.e_da));
            chk($sformatf("v%0d_fwd_hit_b", i), 64'(fwd_hit_b), 64'(v.e_hb));
            advance();
        end

        // DEPTH=2 instance: the only depth where a single double enqueue fills it.
        ld_valid = 1'b0; alu_valid = 1'b0; rd_adrs_a = '0; rd_adrs_b = '0;
        d2_ld_valid = 1'b1; d2_ld_adrs = 5'd10; d2_ld_data = 'h55;
        d2_alu_valid = 1'b1; d2_alu_adrs = 5'd11; d2_alu_data = 'h66;
        d2_rd_adrs_a = 5'd10;
        #1;
        chk("d2_fill_count", 64'(d2_count), 64'(0));
        chk("d2_fill_ld_ready", 64'(d2_ld_ready), 64'(1));
        chk("d2_fill_alu_ready", 64'(d2_alu_ready), 64'(1));
        @(posedge clk_cpu); @(negedge clk_cpu);
        d2_alu_valid = 1'b0; d2_ld_adrs = 5'd12; d2_ld_data = 'h77; d2_reset = 1'b1;
        #1;
        chk("d2_rst_count", 64'(d2_count), 64'(2));
        chk("d2_rst_full", 64'(d2_full), 64'(1));
        chk("d2_rst_wr_en", 64'(d2_wr_en), 64'(0));
        chk("d2_rst_ld_ready", 64'(d2_ld_ready), 64'(0));
        chk("d2_rst_alu_ready", 64'(d2_alu_ready), 64'(0));
        chk("d2_rst_fwd_hit_a", 64'(d2_fwd_hit_a), 64'(0));
        @(posedge clk_cpu); @(negedge clk_cpu);
        d2_reset = 1'b0; d2_ld_valid = 1'b0;
        #1;
        chk("d2_post_count", 64'(d2_count), 64'(0));
        chk("d2_post_empty", 64'(d2_empty), 64'(1));
        chk("d2_post_full", 64'(d2_full), 64'(0));
        chk("d2_post_wr_en", 64'(d2_wr_en), 64'(0));
        chk("d2_post_fwd_hit_a", 64'(d2_fwd_hit_a), 64'(0));
        @(posedge clk_cpu); @(negedge clk_cpu);
        #1;
        chk("d2_noenq_count", 64'(d2_count), 64'(0));
        chk("d2_noenq_wr_en", 64'(d2_wr_en), 64'(0));
        d2_ld_valid = 1'b1; d2_ld_adrs = 5'd13; d2_ld_data = 'h88;
        d2_alu_valid = 1'b1; d2_alu_adrs = 5'd14; d2_alu_data = 'h99;
        @(posedge clk_cpu); @(negedge clk_cpu);
        #1;
        chk("d2_full_full", 64'(d2_full), 64'(1));
        chk("d2_full_ld_ready", 64'(d2_ld_ready), 64'(0));
        chk("d2_full_alu_ready", 64'(d2_alu_ready), 64'(0));
        chk("d2_full_wr_adrs", 64'(d2_wr_adrs), 64'(13));
        chk("d2_full_wr_data", 64'(d2_wr_data), 64'('h88));
        d2_ld_valid = 1'b0; d2_alu_valid = 1'b0;
        @(posedge clk_cpu); @(negedge clk_cpu);
        #1;
        chk("d2_drain_wr_adrs", 64'(d2_wr_adrs), 64'(14));
        chk("d2_drain_count", 64'(d2_count), 64'(1));
        @(posedge clk_cpu); @(negedge clk_cpu);

        pct = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) pct = (c / 500 % 3 == 0) ? 90 : (c / 500 % 3 == 1) ? 50 : 20;
            reset     = ($urandom_range(0, 299) == 0);
            ld_valid  = ($urandom_range(0, 99) < pct);
            ld_adrs   = 5'($urandom_range(0, 7));
            ld_data   = B_WORD'($urandom);
            alu_valid = ($urandom_range(0, 99) < pct);
            alu_adrs  = 5'($urandom_range(0, 7));
            alu_data  = B_WORD'($urandom);
            rd_adrs_a = 5'($urandom_range(0, 7));
            rd_adrs_b = 5'($urandom_range(0, 7));
            #1;
            model_check();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
